// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed from latched operands and registered on the final busy edge.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   b_div;
    logic [WIDTH-1:0]   quo_mag;
    logic [WIDTH-1:0]   rem_mag;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               b_zero;

    // Low 2*WIDTH bits of an extended product equal the signed/unsigned full product.
    always_comb begin
        if (op_q[0]) begin
            a_ext = {{WIDTH{1'b0}}, a_q};
            b_ext = {{WIDTH{1'b0}}, b_q};
        end else begin
            a_ext = {{WIDTH{a_q[WIDTH-1]}}, a_q};
            b_ext = {{WIDTH{b_q[WIDTH-1]}}, b_q};
        end
        prod = a_ext * b_ext;
    end

    // Sign-magnitude division avoids the MIN/-1 overflow of a native signed divide.
    always_comb begin
        a_neg   = ~op_q[0] & a_q[WIDTH-1];
        b_neg   = ~op_q[0] & b_q[WIDTH-1];
        a_mag   = a_neg ? (WIDTH'(0) - a_q) : a_q;
        b_mag   = b_neg ? (WIDTH'(0) - b_q) : b_q;
        b_zero  = (b_q == WIDTH'(0));
        b_div   = b_zero ? WIDTH'(1) : b_mag;
        quo_mag = a_mag / b_div;
        rem_mag = a_mag % b_div;
        quo     = (a_neg ^ b_neg) ? (WIDTH'(0) - quo_mag) : quo_mag;
        rem     = a_neg ? (WIDTH'(0) - rem_mag) : rem_mag;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = a;
                if (lo_we) lo_d = a;
                if (start) begin
                    state_d = S_RUN;
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    cnt_d   = op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (!op_q[1]) begin
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end else if (!b_zero) begin
                        hi_d = rem;
                        lo_d = quo;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed testbench for mult_div_unit: timing, arithmetic corner cases,
// ignored inputs while busy, async reset and back-to-back launch.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    int          busy_cnt;
    int          early_done;
    logic [31:0] hi1;
    logic [31:0] lo1;

    mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .hi_we (hi_we),
        .lo_we (lo_we),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    // Stimulus only: called at a negedge, returns at the negedge of the done cycle.
    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input int n, input bit mt, input bit perturb);
        op = o; a = x; b = y; start = 1'b1; hi_we = mt; lo_we = mt;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
        hi1 = hi; lo1 = lo; busy_cnt = 0; early_done = 0;
        for (int i = 0; i < n; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) early_done++;
            if (perturb && i == 1) begin
                start = 1'b1; hi_we = 1'b1; lo_we = 1'b1;
                op = 2'b11; a = 32'hDEADBEEF; b = 32'h3;
            end
            if (perturb && i == 2) begin
                start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_hi: got %h exp 0", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_lo: got %h exp 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b exp 0", done); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (hi !== 32'h0 || busy !== 1'b0) begin errors++; $display("FAIL rel_state: hi %h busy %b exp 0 0", hi, busy); end
        a = 32'h1234; hi_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0;
        checks++; if (hi !== 32'h1234) begin errors++; $display("FAIL mthi_hi: got %h exp 1234", hi); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mthi_lo: got %h exp 0", lo); end
        a = 32'h55; lo_we = 1'b1;
        @(negedge clk);
        lo_we = 1'b0;
        checks++; if (lo !== 32'h55 || hi !== 32'h1234) begin errors++; $display("FAIL mtlo: got hi %h lo %h exp 1234 55", hi, lo); end
        a = 32'hA5A5; hi_we = 1'b1; lo_we = 1'b1;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        checks++; if (hi !== 32'hA5A5 || lo !== 32'hA5A5) begin errors++; $display("FAIL mt_both: got hi %h lo %h exp a5a5 a5a5", hi, lo); end
    endtask

    task automatic test_mult;
        run(2'b00, 32'hFFFFFFFD, 32'h7, 5, 1'b0, 1'b0);
        checks++; if (busy_cnt != 5) begin errors++; $display("FAIL mult_busy: got %0d cycles exp 5", busy_cnt); end
        checks++; if (early_done != 0) begin errors++; $display("FAIL mult_early_done: got %0d exp 0", early_done); end
        checks++; if (busy !== 1'b0 || done !== 1'b1) begin errors++; $display("FAIL mult_end: busy %b done %b exp 0 1", busy, done); end
        checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_hi: got %h exp ffffffff", hi); end
        checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_lo: got %h exp ffffffeb", lo); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse: got %b exp 0", done); end
    endtask

    task automatic test_multu;
        run(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 1'b0);
        checks++; if (hi !== 32'hFFFFFFFE || lo !== 32'h1) begin errors++; $display("FAIL multu: got %h_%h exp fffffffe_00000001", hi, lo); end
        @(negedge clk);
        run(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 5, 1'b0, 1'b0);
        checks++; if (hi !== 32'h0 || lo !== 32'h1) begin errors++; $display("FAIL mult_m1m1: got %h_%h exp 00000000_00000001", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_div;
        run(2'b10, 32'hFFFFFFF9, 32'h2, 10, 1'b0, 1'b0);
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL div_busy: got %0d cycles exp 10", busy_cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL div_done: got %b exp 1", done); end
        checks++; if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg: got hi %h lo %h exp ffffffff fffffffd", hi, lo); end
        @(negedge clk);
        run(2'b11, 32'h7, 32'h2, 10, 1'b0, 1'b0);
        checks++; if (lo !== 32'h3 || hi !== 32'h1) begin errors++; $display("FAIL divu: got hi %h lo %h exp 1 3", hi, lo); end
        @(negedge clk);
        run(2'b10, 32'h80000000, 32'hFFFFFFFF, 10, 1'b0, 1'b0);
        checks++; if (lo !== 32'h80000000 || hi !== 32'h0) begin errors++; $display("FAIL div_ovf: got hi %h lo %h exp 0 80000000", hi, lo); end
        @(negedge clk);
        run(2'b11, 32'hFFFFFFF9, 32'h2, 10, 1'b0, 1'b0);
        checks++; if (lo !== 32'h7FFFFFFC || hi !== 32'h1) begin errors++; $display("FAIL divu_big: got hi %h lo %h exp 1 7ffffffc", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        run(2'b11, 32'h7, 32'h2, 10, 1'b0, 1'b0);
        @(negedge clk);
        run(2'b10, 32'h5, 32'h0, 10, 1'b0, 1'b0);
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL dz_busy: got %0d cycles exp 10", busy_cnt); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL dz_done: got %b exp 1", done); end
        checks++; if (hi !== 32'h1 || lo !== 32'h3) begin errors++; $display("FAIL dz_keep: got hi %h lo %h exp 1 3", hi, lo); end
        @(negedge clk);
        run(2'b00, 32'h2, 32'h3, 5, 1'b0, 1'b1);
        checks++; if (busy_cnt != 5) begin errors++; $display("FAIL ign_busy: got %0d cycles exp 5", busy_cnt); end
        checks++; if (hi !== 32'h0 || lo !== 32'h6) begin errors++; $display("FAIL ign_result: got hi %h lo %h exp 0 6", hi, lo); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_relaunch: busy %b exp 0", busy); end
        run(2'b00, 32'h5, 32'h4, 5, 1'b1, 1'b0);
        checks++; if (hi1 !== 32'h5 || lo1 !== 32'h5) begin errors++; $display("FAIL sim_mt: got hi %h lo %h exp 5 5", hi1, lo1); end
        checks++; if (hi !== 32'h0 || lo !== 32'h14) begin errors++; $display("FAIL sim_result: got hi %h lo %h exp 0 14", hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        run(2'b01, 32'h6, 32'h7, 5, 1'b0, 1'b0);
        checks++; if (done !== 1'b1 || lo !== 32'h2A) begin errors++; $display("FAIL b2b_first: done %b lo %h exp 1 2a", done, lo); end
        run(2'b11, 32'h64, 32'h7, 10, 1'b0, 1'b0);
        checks++; if (busy_cnt != 10) begin errors++; $display("FAIL b2b_busy: got %0d cycles exp 10", busy_cnt); end
        checks++; if (early_done != 0) begin errors++; $display("FAIL b2b_early_done: got %0d exp 0", early_done); end
        checks++; if (done !== 1'b1 || hi !== 32'h2 || lo !== 32'hE) begin errors++; $display("FAIL b2b_second: done %b hi %h lo %h exp 1 2 e", done, hi, lo); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int seen;
        op = 2'b00; a = 32'h3; b = 32'h3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b exp 0", busy); end
        checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL mid_hilo: got hi %h lo %h exp 0 0", hi, lo); end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL mid_no_done: %0d active cycles exp 0", seen); end
        checks++; if (lo !== 32'h0) begin errors++; $display("FAIL mid_lo_after: got %h exp 0", lo); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0;
        #1 reset = 1'b0;
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
